// File: rtl/monkey_slot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bloons_pkg
//  Description : Shared constants and state type for the monkey slot
//                controller and its register-file interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package bloons_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/monkey_slot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : monkey_slot_ctrl_if
//  Description : Placement, sell, frame-scan and register-file port bundle
//                of the monkey slot controller. "master" is the controller
//                side, "slave" is the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface monkey_slot_ctrl_if;
    import bloons_pkg::*;

    // placement request / response
    logic                 Place_Req;
    logic [COORD_W-1:0]   Place_X;
    logic [COORD_W-1:0]   Place_Y;
    logic                 Place_Ack;
    logic                 Place_Full;
    // sell
    logic                 Sell_Req;
    logic [SLOT_W-1:0]    Sell_Slot;
    // frame scan
    logic                 Frame_Start;
    logic                 Scan_Valid;
    logic [SLOT_W-1:0]    Scan_Slot;
    logic                 Scan_Ready;
    logic                 Scan_Done;
    logic                 Overrun;
    // register-file ports
    logic                 Load_Reg;
    logic [SLOT_W-1:0]    DRS;
    logic [COORD_W-1:0]   MonkeyX;
    logic [COORD_W-1:0]   MonkeyY;
    logic [SLOT_W-1:0]    SR1S;
    // status
    logic [NUM_SLOTS-1:0] Occupied;
    logic [SLOT_W:0]      Count;

    modport master (
        input  Place_Req, Place_X, Place_Y, Sell_Req, Sell_Slot,
               Frame_Start, Scan_Ready,
        output Place_Ack, Place_Full, Scan_Valid, Scan_Slot, Scan_Done,
               Overrun, Load_Reg, DRS, MonkeyX, MonkeyY, SR1S,
               Occupied, Count
    );

    modport slave (
        output Place_Req, Place_X, Place_Y, Sell_Req, Sell_Slot,
               Frame_Start, Scan_Ready,
        input  Place_Ack, Place_Full, Scan_Valid, Scan_Slot, Scan_Done,
               Overrun, Load_Reg, DRS, MonkeyX, MonkeyY, SR1S,
               Occupied, Count
    );

endinterface
`default_nettype wire

// File: rtl/monkey_slot_ctrl_slot_pick.sv
`default_nettype none
// ============================================================================
//  Module      : slot_pick
//  Description : Lowest-set-bit priority encoder: mask -> index + any flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_pick
    import bloons_pkg::*;
#(
    parameter int MASK_W = NUM_SLOTS,
    parameter int IDX_W  = SLOT_W
) (
    input  wire logic [MASK_W-1:0] i_mask,
    output logic      [IDX_W-1:0]  o_idx,
    output logic                   o_any
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/monkey_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : monkey_slot_ctrl
//  Description : Allocates register-file slots for tower placements and
//                walks every occupied slot once per frame under a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module monkey_slot_ctrl
    import bloons_pkg::*;
(
    input wire logic           Clk,
    input wire logic           Reset,
    monkey_slot_ctrl_if.master bus
);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [NUM_SLOTS-1:0] r_occupied;
    logic [NUM_SLOTS-1:0] r_scan_mask;
    logic [SLOT_W:0]      r_count;
    logic                 r_pending;
    logic                 r_overrun;
    logic                 r_place_full;

    logic                 w_in_place;
    logic                 w_in_scan;
    logic                 w_sell_hit;
    logic [NUM_SLOTS-1:0] w_sell_mask;
    logic [NUM_SLOTS-1:0] w_avail_occ;
    logic [NUM_SLOTS-1:0] w_free_mask;
    logic [NUM_SLOTS-1:0] w_place_mask;
    logic [NUM_SLOTS-1:0] w_scan_onehot;
    logic [NUM_SLOTS-1:0] w_scan_rest;
    logic [SLOT_W-1:0]    w_free_idx;
    logic [SLOT_W-1:0]    w_scan_idx;
    logic                 w_free_any;
    logic                 w_scan_any;
    logic                 w_snapshot;
    logic                 w_pending_set;
    logic                 w_pending_clr;
    logic                 w_full_set;
    logic                 w_scan_accept;
    logic                 w_overrun_set;

    assign w_in_place = (r_state == PLACE);
    assign w_in_scan  = (r_state == SCAN);

    // A sell lands before any same-cycle allocation, so the freed slot is
    // already visible to the free-slot search.
    assign w_sell_hit  = bus.Sell_Req && r_occupied[bus.Sell_Slot];
    assign w_sell_mask = w_sell_hit ? (NUM_SLOTS'(1) << bus.Sell_Slot) : '0;
    assign w_avail_occ = r_occupied & ~w_sell_mask;
    assign w_free_mask = ~w_avail_occ;

    slot_pick u_free_pick (
        .i_mask (w_free_mask),
        .o_idx  (w_free_idx),
        .o_any  (w_free_any)
    );

    slot_pick u_scan_pick (
        .i_mask (r_scan_mask),
        .o_idx  (w_scan_idx),
        .o_any  (w_scan_any)
    );

    assign w_place_mask  = w_in_place ? (NUM_SLOTS'(1) << w_free_idx) : '0;
    assign w_scan_onehot = NUM_SLOTS'(1) << w_scan_idx;
    assign w_scan_rest   = r_scan_mask & ~w_scan_onehot;

    // A frame is only absorbed while a placement already holds it pending.
    assign w_overrun_set = bus.Frame_Start && (r_state != IDLE) && !r_pending;

    // Next-state decode; a pending frame outranks a new placement so the
    // scan starts on the first idle cycle after the write.
    always_comb begin
        w_state_next  = r_state;
        w_snapshot    = 1'b0;
        w_pending_set = 1'b0;
        w_pending_clr = 1'b0;
        w_full_set    = 1'b0;
        w_scan_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_state_next  = SCAN;
                    w_snapshot    = 1'b1;
                    w_pending_clr = 1'b1;
                end else if (bus.Place_Req && w_free_any) begin
                    w_state_next  = PLACE;
                    w_pending_set = bus.Frame_Start;
                end else if (bus.Frame_Start) begin
                    w_state_next  = SCAN;
                    w_snapshot    = 1'b1;
                end else if (bus.Place_Req && !r_place_full) begin
                    w_full_set    = 1'b1;
                end
            end
            PLACE: begin
                w_state_next = IDLE;
            end
            SCAN: begin
                if (!w_scan_any) begin
                    w_state_next = DONE;
                end else if (bus.Scan_Ready) begin
                    w_scan_accept = 1'b1;
                    if (w_scan_rest == '0) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy, scan mask and sticky/pulse flags.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_occupied   <= '0;
            r_count      <= '0;
            r_scan_mask  <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
            r_place_full <= 1'b0;
        end else begin
            r_occupied   <= w_avail_occ | w_place_mask;
            r_count      <= r_count + (SLOT_W+1)'(w_in_place) - (SLOT_W+1)'(w_sell_hit);
            r_place_full <= w_full_set;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
            if (w_pending_clr) begin
                r_pending <= 1'b0;
            end else if (w_pending_set) begin
                r_pending <= 1'b1;
            end
            if (w_snapshot) begin
                r_scan_mask <= r_occupied;
            end else if (w_scan_accept) begin
                r_scan_mask <= w_scan_rest;
            end
        end
    end

    assign bus.Load_Reg   = w_in_place;
    assign bus.Place_Ack  = w_in_place;
    assign bus.DRS        = w_in_place ? w_free_idx : '0;
    assign bus.MonkeyX    = w_in_place ? bus.Place_X : '0;
    assign bus.MonkeyY    = w_in_place ? bus.Place_Y : '0;
    assign bus.Place_Full = r_place_full;
    assign bus.Scan_Valid = w_in_scan && w_scan_any;
    assign bus.Scan_Slot  = bus.Scan_Valid ? w_scan_idx : '0;
    assign bus.SR1S       = bus.Scan_Valid ? w_scan_idx : '0;
    assign bus.Scan_Done  = (r_state == DONE);
    assign bus.Overrun    = r_overrun;
    assign bus.Occupied   = r_occupied;
    assign bus.Count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_monkey_slot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_monkey_slot_ctrl
//  Description : Self-checking bench for monkey_slot_ctrl: directed vector
//                table, multi-cycle reset sequences, random run against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_monkey_slot_ctrl;
    import bloons_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    monkey_slot_ctrl_if bus();

    monkey_slot_ctrl u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit preq; int x; int y; bit sell; int sslot; bit frame; bit ready;
    } in_t;

    typedef struct {
        bit load; int drs; int mx; int my; bit full; bit valid; int slot;
        bit done; bit ovr; int occ; int cnt;
    } out_t;

    typedef struct { in_t i; out_t o; } vec_t;

    vec_t tbl[$];
    in_t  c_idle_in = '{0, 0, 0, 0, 0, 0, 0};
    out_t c_zero_out = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_outs(string tag, out_t e);
        chk({tag, ".Load_Reg"},   32'(bus.Load_Reg),   32'(e.load));
        chk({tag, ".Place_Ack"},  32'(bus.Place_Ack),  32'(e.load));
        chk({tag, ".DRS"},        32'(bus.DRS),        32'(e.drs));
        chk({tag, ".MonkeyX"},    32'(bus.MonkeyX),    32'(e.mx));
        chk({tag, ".MonkeyY"},    32'(bus.MonkeyY),    32'(e.my));
        chk({tag, ".Place_Full"}, 32'(bus.Place_Full), 32'(e.full));
        chk({tag, ".Scan_Valid"}, 32'(bus.Scan_Valid), 32'(e.valid));
        chk({tag, ".Scan_Slot"},  32'(bus.Scan_Slot),  32'(e.slot));
        chk({tag, ".SR1S"},       32'(bus.SR1S),       32'(e.slot));
        chk({tag, ".Scan_Done"},  32'(bus.Scan_Done),  32'(e.done));
        chk({tag, ".Overrun"},    32'(bus.Overrun),    32'(e.ovr));
        chk({tag, ".Occupied"},   32'(bus.Occupied),   32'(e.occ));
        chk({tag, ".Count"},      32'(bus.Count),      32'(e.cnt));
    endtask

    task automatic apply(in_t v);
        bus.Place_Req   = v.preq;
        bus.Place_X     = COORD_W'(v.x);
        bus.Place_Y     = COORD_W'(v.y);
        bus.Sell_Req    = v.sell;
        bus.Sell_Slot   = SLOT_W'(v.sslot);
        bus.Frame_Start = v.frame;
        bus.Scan_Ready  = v.ready;
    endtask

    // Drive one cycle's inputs just after the edge; return at the falling edge.
    task automatic step(in_t v);
        @(posedge Clk);
        #1;
        apply(v);
        @(negedge Clk);
    endtask

    function automatic in_t mk_in(bit preq, int x, int y, bit sell, int ss, bit fr, bit rdy);
        in_t v;
        v = '{preq, x, y, sell, ss, fr, rdy};
        return v;
    endfunction

    function automatic void row(bit preq, int x, int y, bit sell, int ss, bit fr, bit rdy,
                                bit load, int drs, bit full, bit valid, int slot,
                                bit done, bit ovr, int occ, int cnt);
        vec_t v;
        v.i = mk_in(preq, x, y, sell, ss, fr, rdy);
        v.o = '{load, drs, load ? x : 0, load ? y : 0, full, valid, slot, done, ovr, occ, cnt};
        tbl.push_back(v);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: occupancy as a bit array, the frame scan as a queue
    // of slot numbers captured at the frame start.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_PLACE, M_SCAN, M_DONE} mph_e;
    mph_e m_ph;
    bit   m_occ[NUM_SLOTS];
    int   m_list[$];
    bit   m_pend;
    bit   m_ovr;
    bit   m_full;

    function automatic void model_reset();
        m_ph = M_IDLE;
        foreach (m_occ[i]) m_occ[i] = 1'b0;
        m_list.delete();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_full = 1'b0;
    endfunction

    function automatic void model_start_scan();
        m_list.delete();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_occ[i]) m_list.push_back(i);
        end
        m_ph = M_SCAN;
    endfunction

    task automatic model_cycle(in_t v);
        bit   after[NUM_SLOTS];
        int   free_slot;
        int   occ_val;
        int   cnt;
        bit   nfull;
        out_t e;
        after = m_occ;
        if (v.sell && m_occ[v.sslot]) after[v.sslot] = 1'b0;
        free_slot = -1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!after[i]) free_slot = i;
        end
        occ_val = 0;
        cnt     = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_occ[i]) begin
                occ_val |= (1 << i);
                cnt++;
            end
        end
        e = c_zero_out;
        if (m_ph == M_PLACE) begin
            e.load = 1'b1;
            e.drs  = free_slot;
            e.mx   = v.x;
            e.my   = v.y;
        end
        if (m_ph == M_SCAN && m_list.size() > 0) begin
            e.valid = 1'b1;
            e.slot  = m_list[0];
        end
        e.done = (m_ph == M_DONE);
        e.full = m_full;
        e.ovr  = m_ovr;
        e.occ  = occ_val;
        e.cnt  = cnt;
        cmp_outs("rand", e);

        if (v.frame && m_ph != M_IDLE && !m_pend) m_ovr = 1'b1;
        nfull = 1'b0;
        case (m_ph)
            M_IDLE: begin
                if (m_pend) begin
                    model_start_scan();
                    m_pend = 1'b0;
                end else if (v.preq && free_slot >= 0) begin
                    m_ph = M_PLACE;
                    if (v.frame) m_pend = 1'b1;
                end else if (v.frame) begin
                    model_start_scan();
                end else if (v.preq && !m_full) begin
                    nfull = 1'b1;
                end
            end
            M_PLACE: begin
                if (free_slot >= 0) after[free_slot] = 1'b1;
                m_ph = M_IDLE;
            end
            M_SCAN: begin
                if (m_list.size() == 0) begin
                    m_ph = M_DONE;
                end else if (v.ready) begin
                    void'(m_list.pop_front());
                    if (m_list.size() == 0) m_ph = M_DONE;
                end
            end
            default: m_ph = M_IDLE;
        endcase
        m_full = nfull;
        m_occ  = after;
    endtask

    task automatic do_reset();
        apply(c_idle_in);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        cmp_outs("reset", c_zero_out);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic place(int x, int y);
        step(mk_in(1, x, y, 0, 0, 0, 0));
        step(mk_in(0, x, y, 0, 0, 0, 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t e;
        int   rx;
        int   ry;
        in_t  rv;

        // ---------------- directed vector table ----------------
        // fill all eight slots; slot k gets X=100+k, Y=200+k
        for (int k = 0; k < NUM_SLOTS; k++) begin
            row(1, 100+k, 200+k, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, (1<<k)-1, k);
            row(0, 100+k, 200+k, 0,0, 0,0,  1,k, 0, 0,0, 0, 0, (1<<k)-1, k);
        end
        // ninth request: rejected, Place_Full every second cycle
        row(1, 9,9, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, 'hFF, 8);
        row(1, 9,9, 0,0, 0,0,  0,0, 1, 0,0, 0, 0, 'hFF, 8);
        row(1, 9,9, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, 'hFF, 8);
        row(0, 9,9, 0,0, 0,0,  0,0, 1, 0,0, 0, 0, 'hFF, 8);
        row(0, 0,0, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, 'hFF, 8);
        // sell 0,1,3,4,6 -> occupancy 1010_0100
        row(0, 0,0, 1,0, 0,0,  0,0, 0, 0,0, 0, 0, 'hFF, 8);
        row(0, 0,0, 1,1, 0,0,  0,0, 0, 0,0, 0, 0, 'hFE, 7);
        row(0, 0,0, 1,3, 0,0,  0,0, 0, 0,0, 0, 0, 'hFC, 6);
        row(0, 0,0, 1,4, 0,0,  0,0, 0, 0,0, 0, 0, 'hF4, 5);
        row(0, 0,0, 1,6, 0,0,  0,0, 0, 0,0, 0, 0, 'hE4, 4);
        row(0, 0,0, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, 'hA4, 3);
        // scan with Ready held: 2, 5, 7, done
        row(0, 0,0, 0,0, 1,1,  0,0, 0, 0,0, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,2, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,5, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,7, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 0,0, 1, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 0,0, 0, 0, 'hA4, 3);
        // scan stalled three cycles on slot 2
        row(0, 0,0, 0,0, 1,0,  0,0, 0, 0,0, 0, 0, 'hA4, 3);
        for (int k = 0; k < 3; k++)
            row(0, 0,0, 0,0, 0,0,  0,0, 0, 1,2, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,2, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,5, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,7, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 0,0, 1, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, 'hA4, 3);
        // sell slot 5 while slot 2 is presented: 5 still scanned
        row(0, 0,0, 0,0, 1,1,  0,0, 0, 0,0, 0, 0, 'hA4, 3);
        row(0, 0,0, 1,5, 0,1,  0,0, 0, 1,2, 0, 0, 'hA4, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,5, 0, 0, 'h84, 2);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,7, 0, 0, 'h84, 2);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 0,0, 1, 0, 'h84, 2);
        row(0, 0,0, 0,0, 0,0,  0,0, 0, 0,0, 0, 0, 'h84, 2);
        // placement and frame together, then a frame during the scan
        row(1, 300,400, 0,0, 1,0,  0,0, 0, 0,0, 0, 0, 'h84, 2);
        row(0, 300,400, 0,0, 0,0,  1,0, 0, 0,0, 0, 0, 'h84, 2);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 0,0, 0, 0, 'h85, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,0, 0, 0, 'h85, 3);
        row(0, 0,0, 0,0, 1,1,  0,0, 0, 1,2, 0, 0, 'h85, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 1,7, 0, 1, 'h85, 3);
        row(0, 0,0, 0,0, 0,1,  0,0, 0, 0,0, 1, 1, 'h85, 3);
        row(0, 0,0, 0,0, 0,0,  0,0, 0, 0,0, 0, 1, 'h85, 3);

        apply(c_idle_in);
        do_reset();
        foreach (tbl[k]) begin
            step(tbl[k].i);
            cmp_outs($sformatf("tbl%0d", k), tbl[k].o);
        end

        // ---------------- empty snapshot ----------------
        do_reset();
        step(mk_in(0, 0,0, 0,0, 1,1));
        cmp_outs("empty.c0", c_zero_out);
        step(c_idle_in);
        cmp_outs("empty.c1", c_zero_out);
        step(c_idle_in);
        e = c_zero_out;
        e.done = 1'b1;
        cmp_outs("empty.c2", e);
        step(c_idle_in);
        cmp_outs("empty.c3", c_zero_out);

        // ---------------- async reset during a placement ----------------
        place(11, 22);
        step(mk_in(1, 55, 66, 0,0, 0,0));
        step(mk_in(0, 55, 66, 0,0, 0,0));
        e = '{1, 1, 55, 66, 0, 0, 0, 0, 0, 'h01, 1};
        cmp_outs("place_rst.pre", e);
        #1;
        Reset = 1'b0;
        #1;
        cmp_outs("place_rst.in", c_zero_out);
        @(negedge Clk);
        Reset = 1'b1;
        step(c_idle_in);
        cmp_outs("place_rst.post", c_zero_out);

        // ---------------- async reset during a scan ----------------
        model_reset();
        place(1, 2);
        place(3, 4);
        step(mk_in(0, 0,0, 0,0, 1,0));
        step(mk_in(0, 0,0, 0,0, 1,0));
        e = c_zero_out;
        e.valid = 1'b1; e.slot = 0; e.occ = 'h03; e.cnt = 2;
        cmp_outs("scan_rst.pre", e);
        step(mk_in(0, 0,0, 0,0, 0,0));
        e.ovr = 1'b1;
        cmp_outs("scan_rst.ovr", e);
        #1;
        Reset = 1'b0;
        #1;
        cmp_outs("scan_rst.in", c_zero_out);
        @(negedge Clk);
        Reset = 1'b1;

        // ---------------- random run against the model ----------------
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            rx = 0;
            ry = 0;
            rv = c_idle_in;
            for (int n = 0; n < 2000; n++) begin
                if (!rv.preq) begin
                    rx = $urandom_range(0, 1023);
                    ry = $urandom_range(0, 1023);
                end
                rv.preq  = ($urandom_range(0, 2) != 0);
                rv.x     = rx;
                rv.y     = ry;
                rv.sell  = ($urandom_range(0, 5) == 0);
                rv.sslot = $urandom_range(0, NUM_SLOTS - 1);
                rv.frame = (seg == 0) ? ($urandom_range(0, 39) == 0)
                                      : ($urandom_range(0, 7) == 0);
                rv.ready = ($urandom_range(0, 3) != 0);
                step(rv);
                model_cycle(rv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
